edge_event_detector: RTL

- Multi-channel, parametrised successor of the single-channel edge pulse generator.
- Each of CHANNELS asynchronous inputs passes through a synchroniser, an optional stable-count glitch filter and a per-channel edge-mode selector.
- Outputs per channel: an extendable pulse and a sticky event flag. A single maskable, registered interrupt summarises the sticky flags.
- Sits between raw board/camera status pins (vsync, button, sensor strobes) and the control/HPS register block.

---
 rtl/edge_detect_pkg.sv | 15 +
 rtl/edge_channel.sv | 72 +++++++
 rtl/edge_event_detector.sv | 49 ++++
 3 files changed

// File: rtl/edge_detect_pkg.sv
// edge_detect_pkg: edge-mode encoding and counter width helper shared by the edge event detector.
package edge_detect_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } teEdgeMode;

    function automatic int cntWidth(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/edge_channel.sv
// edge_channel: one input channel with sync chain, stable-count filter, arming, edge select and pulse stretcher.
module edge_channel
    import edge_detect_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 0,
    parameter int PULSE_EXT     = 1
) (
    input  logic       ul1Clock,
    input  logic       ul1Reset,
    input  logic       ul1SignalIn,
    input  logic [1:0] ul2Mode,
    output logic       ul1Detect,
    output logic       ul1Pulse
);

    localparam int FW = cntWidth(FILTER_CYCLES);
    localparam int PW = cntWidth(PULSE_EXT);

    logic [SYNC_STAGES-1:0] ulvSync;
    logic [SYNC_STAGES-1:0] ulvPrimed;
    logic [FW-1:0]          ulvFiltCnt;
    logic [PW-1:0]          ulvPulseCnt;
    logic                   ul1Filt;
    logic                   ul1Prev;
    logic                   ul1Armed;
    logic                   ul1SyncOut;
    teEdgeMode              eMode;

    assign ul1SyncOut = ulvSync[SYNC_STAGES-1];
    assign eMode      = teEdgeMode'(ul2Mode);
    assign ul1Detect  = ul1Armed & (ul1Filt ^ ul1Prev) &
                        ((eMode == EDGE_BOTH) | (eMode == EDGE_RISE & ul1Filt) | (eMode == EDGE_FALL & ~ul1Filt));
    assign ul1Pulse   = ulvPulseCnt != '0;

    // ulvPrimed tracks when the sync output holds a real sample; arming loads it directly so a held level never reports an edge
    always_ff @(posedge ul1Clock) begin
        if (ul1Reset) begin
            ulvSync     <= '0;
            ulvPrimed   <= '0;
            ulvFiltCnt  <= '0;
            ulvPulseCnt <= '0;
            ul1Filt     <= 1'b0;
            ul1Prev     <= 1'b0;
            ul1Armed    <= 1'b0;
        end else begin
            ulvSync     <= {ulvSync[SYNC_STAGES-2:0], ul1SignalIn};
            ulvPrimed   <= {ulvPrimed[SYNC_STAGES-2:0], 1'b1};
            ulvPulseCnt <= ul1Detect ? PW'(PULSE_EXT) : ulvPulseCnt - PW'(ulvPulseCnt != '0);
            if (!ul1Armed) begin
                if (ulvPrimed[SYNC_STAGES-1]) begin
                    ul1Filt  <= ul1SyncOut;
                    ul1Prev  <= ul1SyncOut;
                    ul1Armed <= 1'b1;
                end
            end else begin
                ul1Prev <= ul1Filt;
                if (FILTER_CYCLES == 0) begin
                    ul1Filt <= ul1SyncOut;
                end else if (ul1SyncOut == ul1Filt) begin
                    ulvFiltCnt <= '0;
                end else if (ulvFiltCnt == FW'(FILTER_CYCLES)) begin
                    ul1Filt    <= ul1SyncOut;
                    ulvFiltCnt <= '0;
                end else begin
                    ulvFiltCnt <= ulvFiltCnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/edge_event_detector.sv
// edge_event_detector: multi-channel edge pulses with sticky event flags and a masked, registered interrupt.
module edge_event_detector
    import edge_detect_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 0,
    parameter int PULSE_EXT     = 1
) (
    input  logic                  ul1Clock,
    input  logic                  ul1Reset,
    input  logic [CHANNELS-1:0]   ulvSignalIn,
    input  logic [2*CHANNELS-1:0] ulvEdgeMode,
    input  logic [CHANNELS-1:0]   ulvEventClear,
    input  logic [CHANNELS-1:0]   ulvIrqMask,
    output logic [CHANNELS-1:0]   ulvPulseOut,
    output logic [CHANNELS-1:0]   ulvEventSticky,
    output logic                  ul1Irq
);

    logic [CHANNELS-1:0] ulvDetect;

    for (genvar c = 0; c < CHANNELS; c++) begin : gChannel
        edge_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .FILTER_CYCLES(FILTER_CYCLES),
            .PULSE_EXT    (PULSE_EXT)
        ) uChannel (
            .ul1Clock   (ul1Clock),
            .ul1Reset   (ul1Reset),
            .ul1SignalIn(ulvSignalIn[c]),
            .ul2Mode    (ulvEdgeMode[2*c +: 2]),
            .ul1Detect  (ulvDetect[c]),
            .ul1Pulse   (ulvPulseOut[c])
        );
    end

    // set has priority over clear so an event landing on a clear strobe is never lost
    always_ff @(posedge ul1Clock) begin
        if (ul1Reset) begin
            ulvEventSticky <= '0;
            ul1Irq         <= 1'b0;
        end else begin
            ulvEventSticky <= (ulvEventSticky & ~ulvEventClear) | ulvDetect;
            ul1Irq         <= |(ulvEventSticky & ulvIrqMask);
        end
    end

endmodule
